// File: rtl/bank_pkg.sv
// rtl/bank_pkg.sv - shared bank constants and read-tag types
package bank_pkg;

  localparam int NUM_BANKS  = 4;
  localparam int BANK_SEL_W = 2;

  typedef logic [BANK_SEL_W-1:0] bank_sel_t;

  typedef struct packed {
    logic      valid;
    bank_sel_t sel;
  } rd_tag_t;

endpackage

// File: rtl/rd_ret_fifo.sv
// rtl/rd_ret_fifo.sv - show-ahead return FIFO with full/empty flags
module rd_ret_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Head is forced to zero while empty so no stale entry is ever visible
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array: written at the tail, no reset needed since reads are gated by empty
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bank_rd_collect.sv
// rtl/bank_rd_collect.sv - bank read-return collector; BANK_ID_OUT_EN adds o_rd_bank
module bank_rd_collect
  import bank_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd_req,
  input  logic [1:0]        i_rd_sel,
  output logic              o_req_ready,
  input  logic [DATA_W-1:0] i_bank_data0,
  input  logic [DATA_W-1:0] i_bank_data1,
  input  logic [DATA_W-1:0] i_bank_data2,
  input  logic [DATA_W-1:0] i_bank_data3,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic              o_busy
`ifdef BANK_ID_OUT_EN
  ,
  output logic [1:0]        o_rd_bank
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef BANK_ID_OUT_EN
  localparam int ENTRY_W = DATA_W + BANK_SEL_W;
`else
  localparam int ENTRY_W = DATA_W;
`endif

  rd_tag_t             r_tag [RD_LAT];
  logic [CNT_W-1:0]    r_credit;
  rd_tag_t             w_last;
  logic                w_accept;
  logic                w_pop;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [DATA_W-1:0]   w_bank_data;
  logic [ENTRY_W-1:0]  w_push_entry;
  logic [ENTRY_W-1:0]  w_head;

  // Ready depends only on the credit register, never on i_rd_req
  assign o_req_ready = (r_credit < CNT_W'(DEPTH));
  assign o_busy      = (r_credit != '0);
  assign w_accept    = i_rd_req && o_req_ready;
  assign o_rd_valid  = !w_fifo_empty;
  assign w_pop       = o_rd_valid && i_rd_ready;
  assign w_last      = r_tag[RD_LAT-1];

  // Tag pipeline: one stage per cycle of bank latency, last stage marks capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_accept, sel: i_rd_sel};
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Bank data mux steered by the tag reaching the end of the pipeline
  always_comb begin
    w_bank_data = '0;
    case (w_last.sel)
      2'd0:    w_bank_data = i_bank_data0;
      2'd1:    w_bank_data = i_bank_data1;
      2'd2:    w_bank_data = i_bank_data2;
      default: w_bank_data = i_bank_data3;
    endcase
  end

`ifdef BANK_ID_OUT_EN
  assign w_push_entry = {w_last.sel, w_bank_data};
  assign o_rd_data    = w_head[DATA_W-1:0];
  assign o_rd_bank    = w_head[ENTRY_W-1 -: BANK_SEL_W];
`else
  assign w_push_entry = w_bank_data;
  assign o_rd_data    = w_head;
`endif

  // Credit counts in-flight plus queued reads; it bounds FIFO occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_credit <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_credit <= r_credit + CNT_W'(1);
        2'b01:   r_credit <= r_credit - CNT_W'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

  rd_ret_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_last.valid),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Banks cannot stall, so a capture must always find room in the queue
  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_last.valid && w_fifo_full));

endmodule

// File: tb/tb_bank_rd_collect.sv
// tb/tb_bank_rd_collect.sv - bench for bank_rd_collect at RD_LAT 2 and 4
module tb_bank_rd_collect;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [1:0] sel;
  logic       ready;
  logic [DW-1:0] bd [4];

  logic [DW-1:0] rd_data   [2];
  logic          rd_valid  [2];
  logic          req_ready [2];
  logic          busy      [2];
  logic [1:0]    rd_bank   [2];

  int lat [2] = '{2, 4};
  int cyc = 0;
  int total = 0;
  int passed = 0;

  // reference model: per instance, pending reads (due cycle*4 + sel), visible queue {sel,data}, credits
  int         pq  [2][$];
  logic [9:0] oq  [2][$];
  int         cnt [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bank_rd_collect #(.DATA_W(DW), .RD_LAT(2), .DEPTH(DEPTH)) dut_l2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_req(req), .i_rd_sel(sel),
    .o_req_ready(req_ready[0]),
    .i_bank_data0(bd[0]), .i_bank_data1(bd[1]), .i_bank_data2(bd[2]), .i_bank_data3(bd[3]),
    .o_rd_data(rd_data[0]), .o_rd_valid(rd_valid[0]), .i_rd_ready(ready), .o_busy(busy[0])
`ifdef BANK_ID_OUT_EN
    , .o_rd_bank(rd_bank[0])
`endif
  );

  bank_rd_collect #(.DATA_W(DW), .RD_LAT(4), .DEPTH(DEPTH)) dut_l4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd_req(req), .i_rd_sel(sel),
    .o_req_ready(req_ready[1]),
    .i_bank_data0(bd[0]), .i_bank_data1(bd[1]), .i_bank_data2(bd[2]), .i_bank_data3(bd[3]),
    .o_rd_data(rd_data[1]), .o_rd_valid(rd_valid[1]), .i_rd_ready(ready), .o_busy(busy[1])
`ifdef BANK_ID_OUT_EN
    , .o_rd_bank(rd_bank[1])
`endif
  );

  typedef struct {
    logic        req;
    logic [1:0]  sel;
    logic        rdy;
    logic [31:0] d;
    logic        ev;
    logic [7:0]  ed;
    logic        er;
    logic        eb;
    logic [1:0]  ebank;
  } vec_t;

  vec_t vt [11];

  task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s inst=lat%0d got=%0h want=%0h at cyc %0d", nm, lat[i], act, exp, cyc);
    else passed++;
  endtask

  task automatic compare_all(input string nm);
    logic [9:0] h;
    for (int i = 0; i < 2; i++) begin
      check({nm, "/valid"}, i, 32'(rd_valid[i]), 32'(oq[i].size() > 0));
      check({nm, "/req_ready"}, i, 32'(req_ready[i]), 32'(cnt[i] < DEPTH));
      check({nm, "/busy"}, i, 32'(busy[i]), 32'(cnt[i] != 0));
      if (oq[i].size() > 0) begin
        h = oq[i][0];
        check({nm, "/data"}, i, 32'(rd_data[i]), 32'(h[7:0]));
`ifdef BANK_ID_OUT_EN
        check({nm, "/bank"}, i, 32'(rd_bank[i]), 32'(h[9:8]));
`endif
      end
    end
  endtask

  // drive one cycle at the negedge, advance the model, compare at the next negedge
  task automatic cycle(input logic r, input logic [1:0] s, input logic rr, input logic [31:0] d, input string nm);
    int e;
    int acc;
    int pop;
    req = r; sel = s; ready = rr;
    for (int k = 0; k < 4; k++) bd[k] = d[8*k +: 8];
    for (int i = 0; i < 2; i++) begin
      pop = (oq[i].size() > 0 && rr) ? 1 : 0;
      acc = (r && cnt[i] < DEPTH) ? 1 : 0;
      if (pop != 0) void'(oq[i].pop_front());
      while (pq[i].size() > 0 && (pq[i][0] / 4) == cyc) begin
        e = pq[i].pop_front();
        oq[i].push_back({2'(e % 4), bd[e % 4]});
      end
      if (acc != 0) pq[i].push_back((cyc + lat[i]) * 4 + int'(s));
      cnt[i] = cnt[i] + acc - pop;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all(nm);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pq[i].delete();
      oq[i].delete();
      cnt[i] = 0;
    end
  endtask

  task automatic check_reset_state(input string nm);
    for (int i = 0; i < 2; i++) begin
      check({nm, "/valid"}, i, 32'(rd_valid[i]), 32'd0);
      check({nm, "/req_ready"}, i, 32'(req_ready[i]), 32'd1);
      check({nm, "/busy"}, i, 32'(busy[i]), 32'd0);
      check({nm, "/data"}, i, 32'(rd_data[i]), 32'd0);
`ifdef BANK_ID_OUT_EN
      check({nm, "/bank"}, i, 32'(rd_bank[i]), 32'd0);
`endif
    end
  endtask

  initial begin
    int nacc;
    rst_n = 1'b0; req = 1'b0; sel = 2'd0; ready = 1'b0;
    for (int k = 0; k < 4; k++) bd[k] = '0;
    model_reset();

    // single read (sel 2, A5 at T+2), then a 4-beat stream with one accept+pop at credit 3
    vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h00000000, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0};
    vt[1]  = '{1'b0, 2'd0, 1'b0, 32'h00000000, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0};
    vt[2]  = '{1'b0, 2'd0, 1'b0, 32'h00A50000, 1'b1, 8'hA5, 1'b1, 1'b1, 2'd2};
    vt[3]  = '{1'b0, 2'd0, 1'b1, 32'h00000000, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0};
    vt[4]  = '{1'b1, 2'd0, 1'b1, 32'h13121110, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0};
    vt[5]  = '{1'b1, 2'd1, 1'b1, 32'h13121110, 1'b0, 8'h00, 1'b1, 1'b1, 2'd0};
    vt[6]  = '{1'b1, 2'd2, 1'b1, 32'h13121110, 1'b1, 8'h10, 1'b1, 1'b1, 2'd0};
    vt[7]  = '{1'b1, 2'd3, 1'b1, 32'h13121110, 1'b1, 8'h11, 1'b1, 1'b1, 2'd1};
    vt[8]  = '{1'b0, 2'd0, 1'b1, 32'h13121110, 1'b1, 8'h12, 1'b1, 1'b1, 2'd2};
    vt[9]  = '{1'b0, 2'd0, 1'b1, 32'h13121110, 1'b1, 8'h13, 1'b1, 1'b1, 2'd3};
    vt[10] = '{1'b0, 2'd0, 1'b1, 32'h13121110, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0};

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 11; k++) begin
      cycle(vt[k].req, vt[k].sel, vt[k].rdy, vt[k].d, "tbl_model");
      check("tbl/valid", 0, 32'(rd_valid[0]), 32'(vt[k].ev));
      check("tbl/req_ready", 0, 32'(req_ready[0]), 32'(vt[k].er));
      check("tbl/busy", 0, 32'(busy[0]), 32'(vt[k].eb));
      if (vt[k].ev) begin
        check("tbl/data", 0, 32'(rd_data[0]), 32'(vt[k].ed));
`ifdef BANK_ID_OUT_EN
        check("tbl/bank", 0, 32'(rd_bank[0]), 32'(vt[k].ebank));
`endif
      end
    end
    repeat (6) cycle(1'b0, 2'd0, 1'b1, $urandom, "drain0");

    // backpressure: six requests with ready low, only DEPTH accepted
    nacc = 0;
    for (int k = 0; k < 6; k++) begin
      if (req_ready[0]) nacc++;
      cycle(1'b1, 2'($urandom_range(0, 3)), 1'b0, $urandom, "bp_fill");
      if (k == 3) check("bp_ready_after_4th", 0, 32'(req_ready[0]), 32'd0);
    end
    check("bp_accepted", 0, 32'(nacc), 32'd4);
    req = 1'b0;
    repeat (12) cycle(1'b0, 2'd0, 1'b1, $urandom, "bp_drain");
    check("bp_ready_back", 0, 32'(req_ready[0]), 32'd1);

    // reset with two reads queued and two in flight (RD_LAT=2 instance)
    for (int k = 0; k < 4; k++) cycle(1'b1, 2'(k), 1'b0, $urandom, "rst_fill");
    check("rst_pre_busy", 0, 32'(busy[0]), 32'd1);
    check("rst_pre_valid", 0, 32'(rd_valid[0]), 32'd1);
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state("rst_mid");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) cycle(1'b0, 2'd0, 1'b1, $urandom, "rst_after");

    // random sweep with random select, data and ready
    for (int k = 0; k < 500; k++) begin
      cycle($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), $urandom_range(0, 9) < 7, $urandom, "rand");
    end
    repeat (12) cycle(1'b0, 2'd0, 1'b1, $urandom, "rand_drain");
    for (int i = 0; i < 2; i++) check("end_busy", i, 32'(busy[i]), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bank_rd_collect.md
# bank_rd_collect

Read-return collector for the 4-bank memory: the return-path counterpart of the bank-enable demux. For each accepted read it records the 2-bit bank select and waits the fixed bank read latency. It then picks that bank's read data out of the four bank outputs and queues it in order for the requester under a valid/ready handshake. Credit-based flow control on the request side guarantees banks, which cannot stall, never overflow the return queue.

## Interface
- DATA_W, 8: width of each bank's read data (codeword width when Hamming-encoded)
- RD_LAT, 1: bank read latency in cycles, legal 1..4
- DEPTH, 4: return-queue depth and max outstanding reads, power of two, 2..16

- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_rd_req  input  1  read request, same cycle the demux enables the bank
- i_rd_sel  input  2  bank select of the request (00..11 → bank 0..3)
- o_req_ready  output  1  request may be accepted this cycle
- i_bank_data0..3  input  DATA_W each  read data from banks 0..3
- o_rd_data  output  DATA_W  head-of-queue read data
- o_rd_valid  output  1  o_rd_data is valid
- i_rd_ready  input  1  requester takes o_rd_data this cycle
- o_busy  output  1  any read in flight or queued
- o_rd_bank  output  2  bank of head entry (only with BANK_ID_OUT_EN)

## Operation
- Accept = i_rd_req && o_req_ready. Requests while o_req_ready=0 are ignored; the upstream must hold them.
- Tag pipeline: RD_LAT-stage shift register of {valid, sel}. On accept, stage 0 loads {1, i_rd_sel}; otherwise {0, xx}.
- Capture: when the last stage is valid, mux i_bank_data[sel] and push it to the FIFO in that cycle.
- FIFO: DEPTH entries, show-ahead. o_rd_valid = !empty; o_rd_data = head; pop on o_rd_valid && i_rd_ready. Read order equals request order.
- Credit counter, width clog2(DEPTH)+1: +1 on accept, −1 on pop, unchanged on simultaneous accept+pop.
  - o_req_ready = (credit < DEPTH).
  - o_busy = (credit != 0).
- FIFO push can never find the FIFO full, because credit bounds in-flight plus queued entries. A push while full is an assertion failure.
- Push and pop in the same cycle are both performed. Pop of the last entry combined with a push leaves exactly one entry.
- Pointers wrap modulo DEPTH.
- Reset (async assert, any time):
  - tag pipeline cleared; in-flight reads are dropped
  - FIFO emptied, credit = 0
  - o_rd_valid=0, o_req_ready=1, o_busy=0, o_rd_data=0, o_rd_bank=0

## Timing
- Accept in cycle T → bank data sampled in cycle T+RD_LAT → o_rd_valid high from cycle T+RD_LAT+1 at the earliest.
- Back-to-back accepts sustain one return per cycle while i_rd_ready=1.
- o_req_ready drops in the cycle after credit reaches DEPTH. It rises the cycle after the pop that frees a credit.
- No combinational path from i_rd_req or i_rd_ready to any output except via registered state.
  - Exception: o_req_ready depends only on the credit register.

## Configuration
- BANK_ID_OUT_EN defined:
  - FIFO entries are DATA_W+2 bits wide, storing the bank select with the data.
  - o_rd_bank present, reflecting the head entry's bank.
- Undefined: port absent and entries are DATA_W bits. All other behaviour is identical.

## Structure
- Shared package bank_pkg holds:
  - NUM_BANKS=4
  - BANK_SEL_W=2
  - typedef bank_sel_t (logic [1:0])
  - typedef rd_tag_t (struct: valid, bank_sel_t sel)
- One sub-module, rd_ret_fifo (parameterised width/depth show-ahead FIFO with full/empty). The tag pipeline, mux and credit counter live in bank_rd_collect.

## Test plan
- Single read, RD_LAT=2: accept sel=2'b10 at T with i_bank_data2=8'hA5 during T+2 → o_rd_valid=1, o_rd_data=8'hA5 at T+3, o_rd_bank=2'b10 (if enabled).
- Streaming: sels 0,1,2,3 on consecutive cycles, bank data 8'h10..8'h13, i_rd_ready=1 → four consecutive valid beats 8'h10,11,12,13 in order, o_busy low after the last pop.
- Backpressure, DEPTH=4: i_rd_ready=0, issue 6 requests → exactly 4 accepted, o_req_ready=0 after the 4th. Raise i_rd_ready → data drains in order and o_req_ready returns to 1.
- Simultaneous accept+pop at credit=DEPTH−1 → credit stays DEPTH−1 and o_req_ready stays 1.
- Reset mid-operation: assert i_rst_n=0 with 2 reads in flight and 2 queued → o_rd_valid=0, o_busy=0, o_req_ready=1 immediately. No stale data appears after release.
- RD_LAT=4 sweep with random sel/ready → scoreboard matches bank data per request, with no drops or duplicates.
